round_key_server: RTL and testbench

//   Registered buffer and sequencer between the combinational key expansion
//   and the iterative cipher/inverse-cipher datapath. On key_load it captures
//   the full expanded schedule (Nb*(Nr+1) words). On start it streams one

---
 rtl/round_key_server.sv | 102 ++++++++++
 tb/tb_round_key_server.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_key_server.sv
// Round-key buffer/sequencer: captures an expanded AES key schedule and streams
// one registered round key per valid/ready handshake, ascending or descending.
module round_key_server #(
    parameter int Nb = 4,
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_load,
    input  logic [32*Nb*(Nr+1)-1:0]  word_in,
    input  logic                     start,
    input  logic                     decrypt,
    input  logic                     rk_ready,
    output logic                     rk_valid,
    output logic [32*Nb-1:0]         rk_data,
    output logic [3:0]               rk_round,
    output logic                     rk_last,
    output logic                     busy,
    output logic                     key_ok,
    output logic                     done
);
    localparam int RKW  = 32 * Nb;
    localparam int NKEY = Nr + 1;
    localparam int TOTW = RKW * NKEY;
    localparam logic [3:0] NR4 = 4'(Nr);

    if (Nb != 4 || Nr != Nk + 6 || Nr > 14) begin : g_bad_cfg
        $error("round_key_server: unsupported Nb/Nk/Nr combination");
    end

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state;
    logic              dir;
    logic [TOTW-1:0]   store;

    logic              nxt_dir;
    logic [3:0]        nxt_r;
    logic [3:0]        idx_r;
    logic              nxt_last;
    logic [RKW-1:0]    nxt_key;

    // Next key to present: the first one on start, the stepped one in STREAM.
    // Round 0 sits at the MSB end of the store.
    always_comb begin
        nxt_dir  = (state == IDLE) ? decrypt : dir;
        nxt_r    = (state == IDLE) ? (decrypt ? NR4 : 4'd0)
                                   : (dir ? rk_round - 4'd1 : rk_round + 4'd1);
        idx_r    = (nxt_r > NR4) ? NR4 : nxt_r;
        nxt_last = nxt_dir ? (nxt_r == 4'd0) : (nxt_r == NR4);
        nxt_key  = store[(NKEY - 1 - int'(idx_r)) * RKW +: RKW];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            store    <= '0;
            key_ok   <= 1'b0;
            dir      <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_round <= '0;
            rk_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_load) begin
                        store  <= word_in;
                        key_ok <= 1'b1;
                    end else if (start && key_ok) begin
                        state    <= STREAM;
                        dir      <= decrypt;
                        busy     <= 1'b1;
                        rk_valid <= 1'b1;
                        rk_round <= nxt_r;
                        rk_data  <= nxt_key;
                        rk_last  <= nxt_last;
                    end
                end
                STREAM: begin
                    if (rk_valid && rk_ready) begin
                        if (rk_last) begin
                            state    <= IDLE;
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            rk_round <= nxt_r;
                            rk_data  <= nxt_key;
                            rk_last  <= nxt_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_round_key_server.sv
// Directed bench for round_key_server: AES-128 and AES-256 FIPS-197 schedules,
// backpressure, ignored commands, async reset mid-stream.
module tb_round_key_server;
    localparam int W1 = 128 * 11;
    localparam int W2 = 128 * 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            key_load, start, decrypt, rk_ready;
    logic [W1-1:0]   word_in;
    logic            rk_valid, rk_last, busy, key_ok, done;
    logic [127:0]    rk_data;
    logic [3:0]      rk_round;

    logic            key_load2, start2, decrypt2, rk_ready2;
    logic [W2-1:0]   word_in2;
    logic            rk_valid2, rk_last2, busy2, key_ok2, done2;
    logic [127:0]    rk_data2;
    logic [3:0]      rk_round2;

    round_key_server #(.Nb(4), .Nk(4), .Nr(10)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .word_in(word_in),
        .start(start), .decrypt(decrypt), .rk_ready(rk_ready),
        .rk_valid(rk_valid), .rk_data(rk_data), .rk_round(rk_round),
        .rk_last(rk_last), .busy(busy), .key_ok(key_ok), .done(done));

    round_key_server #(.Nb(4), .Nk(8), .Nr(14)) dut2 (
        .clk(clk), .rst(rst), .key_load(key_load2), .word_in(word_in2),
        .start(start2), .decrypt(decrypt2), .rk_ready(rk_ready2),
        .rk_valid(rk_valid2), .rk_data(rk_data2), .rk_round(rk_round2),
        .rk_last(rk_last2), .busy(busy2), .key_ok(key_ok2), .done(done2));

    logic [127:0] e128 [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    logic [127:0] e256 [0:14] = '{
        128'h603deb1015ca71be2b73aef0857d7781, 128'h1f352c073b6108d72d9810a30914dff4,
        128'h9ba354118e6925afa51a8b5f2067fcde, 128'ha8b09c1a93d194cdbe49846eb75d5b9a,
        128'hd59aecb85bf3c917fee94248de8ebe96, 128'hb5a9328a2678a647983122292f6c79b3,
        128'h812c81addadf48ba24360af2fab8b464, 128'h98c5bfc9bebd198e268c3ba709e04214,
        128'h68007bacb2df331696e939e46c518d80, 128'hc814e20476a9fb8a5025c02d59c58239,
        128'hde1369676ccc5a71fa2563959674ee15, 128'h5886ca5d2e2f31d77e0af1fa27cf73c3,
        128'h749c47ab18501ddae2757e4f7401905a, 128'hcafaaae3e4d59b349adf6acebd10190d,
        128'hfe4890d1e6188d0b046df344706c631e};

    logic [W1-1:0] sched1;
    logic [W2-1:0] sched2;
    int total = 0;
    int bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [W1-1:0] k);
        key_load = 1'b1; word_in = k;
        tick();
        key_load = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({rk_valid, rk_data, rk_round, rk_last, busy, key_ok, done} !== '0) begin
            bad++; $display("FAIL reset_outputs got v=%b d=%h r=%0d l=%b b=%b k=%b dn=%b want all 0",
                rk_valid, rk_data, rk_round, rk_last, busy, key_ok, done);
        end
        #10 rst = 1'b0;
        tick();
    endtask

    task automatic test_no_key();
        start = 1'b1; decrypt = 1'b0; rk_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ok !== 1'b0) begin
                bad++; $display("FAIL start_without_key got v=%b b=%b k=%b want 0 0 0", rk_valid, busy, key_ok);
            end
            tick();
        end
    endtask

    // Full-rate stream with ready held high; checks every key, then done pulse.
    task automatic run_stream(input logic dec, input string nm);
        int r;
        start = 1'b1; decrypt = dec; rk_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            r = dec ? 10 - i : i;
            total++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_data !== e128[r] ||
                rk_last !== (i == 10) || busy !== 1'b1) begin
                bad++; $display("FAIL %s_key%0d got v=%b r=%0d l=%b d=%h want r=%0d d=%h",
                    nm, i, rk_valid, rk_round, rk_last, rk_data, r, e128[r]);
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL %s_done got dn=%b v=%b b=%b want 1 0 0", nm, done, rk_valid, busy);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL %s_done_width got dn=%b want 0", nm, done);
        end
    endtask

    task automatic test_encrypt();
        load_key(sched1);
        total++;
        if (key_ok !== 1'b1) begin bad++; $display("FAIL key_ok_after_load got %b want 1", key_ok); end
        run_stream(1'b0, "enc");
    endtask

    task automatic test_decrypt();
        run_stream(1'b1, "dec");
    endtask

    task automatic test_backpressure();
        int i = 0;
        int cyc = 0;
        logic [127:0] pd;
        logic [3:0] pr;
        logic held = 1'b0;
        start = 1'b1; decrypt = 1'b0; rk_ready = 1'b0;
        tick();
        start = 1'b0;
        while (i < 11 && cyc < 300) begin
            rk_ready = 1'($urandom_range(0, 1));
            total++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(i) || rk_data !== e128[i]) begin
                bad++; $display("FAIL bp_key%0d got v=%b r=%0d d=%h want r=%0d d=%h",
                    i, rk_valid, rk_round, rk_data, i, e128[i]);
            end
            if (held) begin
                total++;
                if (rk_data !== pd || rk_round !== pr) begin
                    bad++; $display("FAIL bp_hold got r=%0d d=%h want r=%0d d=%h", rk_round, rk_data, pr, pd);
                end
            end
            held = !rk_ready; pd = rk_data; pr = rk_round;
            if (rk_ready) i++;
            tick();
            cyc++;
        end
        total++;
        if (i != 11 || done !== 1'b1) begin
            bad++; $display("FAIL bp_complete got transfers=%0d dn=%b want 11 1", i, done);
        end
    endtask

    task automatic test_back_to_back();
        run_stream(1'b0, "b2b");
        // run_stream ends one cycle past done; redo with start raised in the done cycle
        start = 1'b1; decrypt = 1'b0; rk_ready = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL b2b_done2 got %b want 1", done); end
        start = 1'b1; decrypt = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (rk_valid !== 1'b1 || rk_round !== 4'd10 || rk_data !== e128[10]) begin
            bad++; $display("FAIL start_in_done_cycle got v=%b r=%0d d=%h want 1 10 %h",
                rk_valid, rk_round, rk_data, e128[10]);
        end
        for (int i = 0; i < 11; i++) tick();
    endtask

    task automatic test_midstream_load();
        start = 1'b1; decrypt = 1'b0; rk_ready = 1'b0;
        tick();
        start = 1'b0;
        key_load = 1'b1; word_in = ~sched1;
        tick(); tick();
        key_load = 1'b0;
        rk_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            total++;
            if (rk_round !== 4'(i) || rk_data !== e128[i]) begin
                bad++; $display("FAIL midload_key%0d got r=%0d d=%h want %0d %h", i, rk_round, rk_data, i, e128[i]);
            end
            tick();
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (rk_valid !== 1'b1 || rk_data !== e128[0]) begin
            bad++; $display("FAIL midload_store_kept got v=%b d=%h want 1 %h", rk_valid, rk_data, e128[0]);
        end
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_midreset();
        int cyc = 0;
        start = 1'b1; decrypt = 1'b0; rk_ready = 1'b1;
        tick();
        start = 1'b0;
        while (rk_round !== 4'd5 && cyc < 20) begin tick(); cyc++; end
        total++;
        if (rk_round !== 4'd5) begin bad++; $display("FAIL reach_round5 got %0d want 5", rk_round); end
        rst = 1'b1;
        #1;
        total++;
        if ({rk_valid, rk_data, rk_round, rk_last, busy, key_ok, done} !== '0) begin
            bad++; $display("FAIL async_reset got v=%b r=%0d d=%h b=%b k=%b want all 0",
                rk_valid, rk_round, rk_data, busy, key_ok);
        end
        #5 rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rk_valid !== 1'b0 || done !== 1'b0 || key_ok !== 1'b0) begin
                bad++; $display("FAIL start_after_reset got v=%b dn=%b k=%b want 0 0 0", rk_valid, done, key_ok);
            end
            tick();
        end
    endtask

    task automatic test_aes256();
        key_load2 = 1'b1; word_in2 = sched2;
        tick();
        key_load2 = 1'b0; start2 = 1'b1; decrypt2 = 1'b0; rk_ready2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            total++;
            if (rk_valid2 !== 1'b1 || rk_round2 !== 4'(i) || rk_data2 !== e256[i] || rk_last2 !== (i == 14)) begin
                bad++; $display("FAIL aes256_key%0d got v=%b r=%0d l=%b d=%h want %h",
                    i, rk_valid2, rk_round2, rk_last2, rk_data2, e256[i]);
            end
            tick();
        end
        total++;
        if (done2 !== 1'b1) begin bad++; $display("FAIL aes256_done got %b want 1", done2); end
    endtask

    initial begin
        key_load = 0; start = 0; decrypt = 0; rk_ready = 0; word_in = '0;
        key_load2 = 0; start2 = 0; decrypt2 = 0; rk_ready2 = 0; word_in2 = '0;
        for (int r = 0; r < 11; r++) sched1[(10 - r) * 128 +: 128] = e128[r];
        for (int r = 0; r < 15; r++) sched2[(14 - r) * 128 +: 128] = e256[r];
        test_reset();
        test_no_key();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_back_to_back();
        test_midstream_load();
        test_midreset();
        test_aes256();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
